// File: rtl/sram_responder.sv
// Behavioural 16-bit asynchronous-SRAM responder with byte enables, optional
// pipelined read latency, saturating access counters and a sticky range-error flag.
module sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        addr_err
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0]       mem_q [DEPTH];
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              wr_cyc;
    logic              rd_cyc;
    logic signed [15:0] rd_data;
    logic [15:0]       dq_out;
    logic              dq_oe;

    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic        addr_err_q, addr_err_d;

    assign in_range = (SRAM_ADDR >> ADDR_W) == 18'd0;
    assign idx      = SRAM_ADDR[ADDR_W-1:0];
    // WE_N wins over OE_N, and nothing on the bus counts while reset is held.
    assign wr_cyc   = rst & ~SRAM_CE_N & ~SRAM_WE_N;
    assign rd_cyc   = rst & ~SRAM_CE_N &  SRAM_WE_N & ~SRAM_OE_N;

    always_comb begin
        rd_data = 16'sh0000;
        if (in_range) begin
            rd_data = mem_q[idx];
            if (SRAM_UB_N) rd_data[15:8] = 8'h00;
            if (SRAM_LB_N) rd_data[7:0]  = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_cyc && in_range) begin
            if (!SRAM_UB_N) mem_q[idx][15:8] <= SRAM_DQ[15:8];
            if (!SRAM_LB_N) mem_q[idx][7:0]  <= SRAM_DQ[7:0];
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        addr_err_d = addr_err_q;
        if (wr_cyc) begin
            if (!in_range)                  addr_err_d = 1'b1;
            else if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        end else if (rd_cyc) begin
            if (!in_range)                  addr_err_d = 1'b1;
            else if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_count_q <= 16'd0;
            rd_count_q <= 16'd0;
            addr_err_q <= 1'b0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            addr_err_q <= addr_err_d;
        end
    end

    generate
        if (READ_LAT == 0) begin : g_async
            assign dq_oe  = rd_cyc;
            assign dq_out = rd_data;
        end else begin : g_pipe
            logic [READ_LAT-1:0] vld_q;
            logic [15:0]         data_q [READ_LAT];

            // stage 0 captures at the read edge; stage READ_LAT-1 drives the bus
            always_ff @(posedge clk) begin
                if (!rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= rd_cyc;
                    for (int i = 1; i < READ_LAT; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                data_q[0] <= rd_data;
                for (int i = 1; i < READ_LAT; i++) data_q[i] <= data_q[i-1];
            end

            assign dq_oe  = vld_q[READ_LAT-1] & rd_cyc;
            assign dq_out = data_q[READ_LAT-1];
        end
    endgenerate

    assign SRAM_DQ  = dq_oe ? dq_out : 16'hzzzz;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
    assign addr_err = addr_err_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench driving one bus into READ_LAT=0 and READ_LAT=2 responders,
// with a byte-level memory model and a queue of pending pipelined read results.
module tb_sram_responder;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] addr = '0;
    logic        ub_n = 1'b1, lb_n = 1'b1, we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1;
    logic        tb_drv = 1'b0;
    logic [15:0] wdata = '0;
    wire  [15:0] dq0, dq2;
    logic [15:0] wr0, rd0, wr2, rd2;
    logic        err0, err2;

    assign dq0 = tb_drv ? wdata : 16'hzzzz;
    assign dq2 = tb_drv ? wdata : 16'hzzzz;

    always #5 clk = ~clk;

    sram_responder #(.ADDR_W(AW), .READ_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq0),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n), .wr_count(wr0), .rd_count(rd0), .addr_err(err0));

    sram_responder #(.ADDR_W(AW), .READ_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq2),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n), .wr_count(wr2), .rd_count(rd2), .addr_err(err2));

    typedef struct { int due; logic [15:0] d; } pend_t;
    pend_t       pq[$];
    logic [15:0] mdl [int];
    logic [15:0] m_wr = 16'd0, m_rd = 16'd0;
    logic        m_err = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [15:0] mdl_read(input logic [17:0] a, input logic ub, input logic lb);
        logic [15:0] d;
        if ((a >> AW) != 18'd0) return 16'h0000;
        d = mdl[int'(a)];
        if (ub) d[15:8] = 8'h00;
        if (lb) d[7:0]  = 8'h00;
        return d;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_ctr();
        check("wr_count_lat0", wr0, m_wr);
        check("rd_count_lat0", rd0, m_rd);
        check("addr_err_lat0", {15'd0, err0}, {15'd0, m_err});
        check("wr_count_lat2", wr2, m_wr);
        check("rd_count_lat2", rd2, m_rd);
        check("addr_err_lat2", {15'd0, err2}, {15'd0, m_err});
    endtask

    // One bus cycle: drive, sample both buses mid-cycle, then model the rising edge.
    task automatic step(input logic rn, input logic we, input logic ce, input logic oe,
                        input logic ub, input logic lb, input logic [17:0] a,
                        input logic [15:0] wd);
        logic        rd_m;
        logic        inr;
        logic [15:0] e0, e2;
        pend_t       p;
        rst = rn; we_n = we; ce_n = ce; oe_n = oe; ub_n = ub; lb_n = lb;
        addr = a; wdata = wd; tb_drv = ~we;
        #1;
        rd_m = rn && !ce && we && !oe;
        inr  = (a >> AW) == 18'd0;
        e0 = !we ? wd : (rd_m ? mdl_read(a, ub, lb) : 16'hzzzz);
        check("dq_lat0", dq0, e0);
        e2 = !we ? wd : 16'hzzzz;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            if (rd_m) e2 = p.d;
        end
        check("dq_lat2", dq2, e2);
        @(posedge clk);
        if (!rn) begin
            m_wr = 16'd0; m_rd = 16'd0; m_err = 1'b0;
            pq.delete();
        end else if (!ce && !we) begin
            if (inr) begin
                if (!mdl.exists(int'(a))) mdl[int'(a)] = 16'h0000;
                if (!ub) mdl[int'(a)][15:8] = wd[15:8];
                if (!lb) mdl[int'(a)][7:0]  = wd[7:0];
                if (m_wr != 16'hFFFF) m_wr++;
            end else m_err = 1'b1;
        end else if (rd_m) begin
            if (inr) begin
                if (m_rd != 16'hFFFF) m_rd++;
            end else m_err = 1'b1;
            pq.push_back('{cyc + 2, mdl_read(a, ub, lb)});
        end
        cyc++;
        #1;
        chk_ctr();
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        step(1'b1, 1'b0, 1'b0, 1'b1, ub, lb, a, d);
    endtask

    task automatic rd(input logic [17:0] a, input logic ub, input logic lb);
        step(1'b1, 1'b1, 1'b0, 1'b0, ub, lb, a, 16'h0000);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0000);
    endtask

    initial begin
        @(posedge clk); #1;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0000);

        // Full write then same-cycle asynchronous read.
        wr(18'd5, 16'hABCD, 1'b0, 1'b0);
        rd(18'd5, 1'b0, 1'b0);
        check("abcd_lat0_const", dq0, 16'hABCD);
        idle();

        // Low-byte-only write over FFFF, then masked reads.
        wr(18'd7, 16'hFFFF, 1'b0, 1'b0);
        wr(18'd7, 16'h1234, 1'b1, 1'b0);
        wr(18'd8, 16'h5678, 1'b1, 1'b1);
        rd(18'd7, 1'b0, 1'b0);
        rd(18'd7, 1'b0, 1'b1);
        rd(18'd7, 1'b1, 1'b0);
        idle();
        idle();

        // Back-to-back pipelined reads after a reset.
        wr(18'd1, 16'h1111, 1'b0, 1'b0);
        wr(18'd2, 16'h2222, 1'b0, 1'b0);
        wr(18'd3, 16'h3333, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0000);
        rd(18'd1, 1'b0, 1'b0);
        rd(18'd2, 1'b0, 1'b0);
        rd(18'd3, 1'b0, 1'b0);
        check("rd_count_three", rd2, 16'd3);
        rd(18'd3, 1'b0, 1'b0);
        rd(18'd3, 1'b0, 1'b0);
        rd(18'd3, 1'b0, 1'b0);
        idle();
        idle();

        // Read on the edge right after a write to the same word.
        wr(18'd9, 16'h0F0F, 1'b0, 1'b0);
        rd(18'd9, 1'b0, 1'b0);
        wr(18'd9, 16'hA5A5, 1'b0, 1'b0);
        rd(18'd9, 1'b0, 1'b0);
        rd(18'd9, 1'b0, 1'b0);
        rd(18'd9, 1'b0, 1'b0);

        // Out-of-range accesses.
        wr(18'd0, 16'h0BEE, 1'b0, 1'b0);
        wr(18'h00400, 16'hDEAD, 1'b0, 1'b0);
        check("oor_err_const", {15'd0, err0}, 16'd1);
        rd(18'd0, 1'b0, 1'b0);
        rd(18'h3FFFF, 1'b0, 1'b0);
        rd(18'd0, 1'b0, 1'b0);
        rd(18'd0, 1'b0, 1'b0);

        // WE_N and OE_N low together: a write, responder stays off the bus.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd12, 16'hC0DE);
        rd(18'd12, 1'b0, 1'b0);
        rd(18'd12, 1'b0, 1'b0);
        rd(18'd12, 1'b0, 1'b0);

        // Chip disabled with OE_N low.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd12, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd12, 16'h0000);

        // Reset pulse while a pipelined read is in flight.
        idle();
        rd(18'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd2, 16'h0000);
        check("rst_rd_count_zero", rd2, 16'd0);
        rd(18'd2, 1'b0, 1'b0);
        rd(18'd2, 1'b0, 1'b0);
        rd(18'd2, 1'b0, 1'b0);
        idle();
        idle();

        if (pq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pending_queue: observed %0d leftover expected 0", pq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the number of implemented word-address bits (depth 2^ADDR_W 16-bit words, range 4..18).
REQ-002 SHALL have parameter READ_LAT, default 0, meaning read latency in clocks (legal 0..3; 0 = asynchronous read).
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL have port SRAM_ADDR, input, 18 bits, word address from the controller.
REQ-006 SHALL have port SRAM_DQ, inout, 16 bits, bidirectional data bus.
REQ-007 SHALL have ports SRAM_UB_N, SRAM_LB_N, input, 1 bit each, active-low byte enables for [15:8] and [7:0].
REQ-008 SHALL have ports SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, input, 1 bit each, active-low write enable, chip enable and output enable.
REQ-009 SHALL have port wr_count, output, 16 bits, number of accepted writes.
REQ-010 SHALL have port rd_count, output, 16 bits, number of accepted reads.
REQ-011 SHALL have port addr_err, output, 1 bit, sticky flag for an access outside the implemented range.

Function
REQ-012 SHALL define in_range as SRAM_ADDR[17:ADDR_W] all zero; idx = SRAM_ADDR[ADDR_W-1:0].
REQ-013 SHALL treat a write cycle as rst=1, CE_N=0, WE_N=0 at a rising edge, regardless of OE_N (WE_N has priority).
REQ-014 SHALL treat a read cycle as rst=1, CE_N=0, WE_N=1, OE_N=0 at a rising edge.
REQ-015 SHALL, on an in-range write, update mem[idx][15:8] from DQ[15:8] only if UB_N=0, and mem[idx][7:0] from DQ[7:0] only if LB_N=0; a write with both byte enables high updates nothing but still counts.
REQ-016 SHALL, on an out-of-range read or write, leave memory unchanged, not increment counters, and set addr_err=1 until reset.
REQ-017 SHALL form read data as mem[idx], with any byte whose enable is high replaced by 8'h00; out-of-range reads return 16'h0000.
REQ-018 SHALL, when READ_LAT=0, drive SRAM_DQ combinationally with the REQ-017 data whenever CE_N=0, WE_N=1 and OE_N=0, tracking SRAM_ADDR changes in the same cycle.
REQ-019 SHALL, when READ_LAT=N>=1, capture {valid, data} at each read cycle into an N-stage shift register (valid=0 on non-read edges) and drive SRAM_DQ from stage N when stage-N valid=1 and current CE_N=0, WE_N=1, OE_N=0.
REQ-020 SHALL hold SRAM_DQ at high impedance in every other case, in particular whenever WE_N=0, CE_N=1 or OE_N=1.
REQ-021 SHALL return the newly written data for a read cycle at the edge immediately after a write to the same address (no stale forwarding).
REQ-022 SHALL increment wr_count per in-range write cycle and rd_count per in-range read cycle, each saturating at 16'hFFFF.
REQ-023 SHALL treat back-to-back read cycles as pipelined: one result per clock after the initial READ_LAT latency.

Reset
REQ-024 SHALL, on a rising edge with rst=0, clear wr_count, rd_count, addr_err and all pipeline valid bits, and float SRAM_DQ from the next cycle.
REQ-025 SHALL discard pending read data when reset is asserted mid-read; no stale value is driven after reset.
REQ-026 SHALL NOT clear memory contents on reset; contents are undefined until written.
REQ-027 SHALL ignore all bus activity while rst=0.

Verification
REQ-028 With READ_LAT=0: write 16'hABCD to address 5, then present a read of address 5 with OE_N=0 -> SRAM_DQ=16'hABCD in the same cycle, and wr_count=1.
REQ-029 Write 16'h1234 to address 7 with UB_N=1, LB_N=0 over prior contents 16'hFFFF -> a read of address 7 returns 16'hFF34; a read with LB_N=1 returns 16'hFF00.
REQ-030 With READ_LAT=2: read cycles to addresses 1, 2 and 3 on consecutive edges -> their data appears on DQ at edges +2, +3 and +4, and rd_count=3.
REQ-031 With ADDR_W=10: write to 18'h00400 -> addr_err=1, wr_count unchanged, and the word at address 0 is unchanged.
REQ-032 Assert rst=0 for one clock while a READ_LAT=2 read is in flight -> DQ stays high-Z, and counters and addr_err read 0.
REQ-033 Drive WE_N=0 and OE_N=0 together -> responder never drives DQ, and the write completes normally.
